// File: rtl/rs_age_param.sv
// rs_age_param: age-ordered reservation station.
//
// Holds up to RS_DEPTH renamed instructions between dispatch and the FU issue
// FIFOs. Source operands are woken by a CDB_W-wide tag broadcast, including
// instructions that are being written in the same cycle. Each cycle up to
// ISSUE_W ready entries are selected oldest first through an age matrix.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   disp_*              DISP_W dispatch lanes (lane 0 oldest in program order)
//   disp_stall          bit k high when fewer than k+1 entries are free
//   free_count          number of invalid entries (registered state only)
//   cdb_valid/cdb_tag   completing destination tags
//   sq_ready            per store-queue slot older-store condition
//   fu_stall            per FU class back-pressure
//   squash              flush every entry at the next edge
//   issue_*             ISSUE_W issue lanes, lane 0 carries the oldest winner
module rs_age_param #(
    parameter int RS_DEPTH  = 16,
    parameter int DISP_W    = 3,
    parameter int ISSUE_W   = 3,
    parameter int CDB_W     = 3,
    parameter int PR_W      = 6,
    parameter int NUM_FU    = 4,
    parameter int SQ_DEPTH  = 8,
    parameter int PAYLOAD_W = 128,
    localparam int FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
    localparam int SQ_W  = (SQ_DEPTH > 1) ? $clog2(SQ_DEPTH) : 1,
    localparam int CNT_W = $clog2(RS_DEPTH + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DISP_W-1:0]                  disp_valid,
    input  logic [DISP_W-1:0][PR_W-1:0]        disp_src1_pr,
    input  logic [DISP_W-1:0][PR_W-1:0]        disp_src2_pr,
    input  logic [DISP_W-1:0]                  disp_src1_rdy,
    input  logic [DISP_W-1:0]                  disp_src2_rdy,
    input  logic [DISP_W-1:0][FU_W-1:0]        disp_fu_sel,
    input  logic [DISP_W-1:0][SQ_W-1:0]        disp_sq_idx,
    input  logic [DISP_W-1:0][PAYLOAD_W-1:0]   disp_payload,
    output logic [DISP_W-1:0]                  disp_stall,
    output logic [CNT_W-1:0]                   free_count,
    input  logic [CDB_W-1:0]                   cdb_valid,
    input  logic [CDB_W-1:0][PR_W-1:0]         cdb_tag,
    input  logic [SQ_DEPTH-1:0]                sq_ready,
    input  logic [NUM_FU-1:0]                  fu_stall,
    input  logic                               squash,
    output logic [ISSUE_W-1:0]                 issue_valid,
    output logic [ISSUE_W-1:0][PR_W-1:0]       issue_src1_pr,
    output logic [ISSUE_W-1:0][PR_W-1:0]       issue_src2_pr,
    output logic [ISSUE_W-1:0][FU_W-1:0]       issue_fu_sel,
    output logic [ISSUE_W-1:0][SQ_W-1:0]       issue_sq_idx,
    output logic [ISSUE_W-1:0][PAYLOAD_W-1:0]  issue_payload
);

    // Stored entry state; age_r[i][j] = 1 means entry i is older than entry j.
    logic [RS_DEPTH-1:0]  valid_r;
    logic [RS_DEPTH-1:0]  src1_rdy_r;
    logic [RS_DEPTH-1:0]  src2_rdy_r;
    logic [PR_W-1:0]      src1_pr_r  [RS_DEPTH];
    logic [PR_W-1:0]      src2_pr_r  [RS_DEPTH];
    logic [FU_W-1:0]      fu_sel_r   [RS_DEPTH];
    logic [SQ_W-1:0]      sq_idx_r   [RS_DEPTH];
    logic [PAYLOAD_W-1:0] payload_r  [RS_DEPTH];
    logic [RS_DEPTH-1:0]  age_r      [RS_DEPTH];

    // Next-state values.
    logic [RS_DEPTH-1:0]  valid_nxt_s;
    logic [RS_DEPTH-1:0]  src1_rdy_nxt_s;
    logic [RS_DEPTH-1:0]  src2_rdy_nxt_s;
    logic [PR_W-1:0]      src1_pr_nxt_s [RS_DEPTH];
    logic [PR_W-1:0]      src2_pr_nxt_s [RS_DEPTH];
    logic [FU_W-1:0]      fu_sel_nxt_s  [RS_DEPTH];
    logic [SQ_W-1:0]      sq_idx_nxt_s  [RS_DEPTH];
    logic [PAYLOAD_W-1:0] payload_nxt_s [RS_DEPTH];
    logic [RS_DEPTH-1:0]  age_nxt_s     [RS_DEPTH];

    // Wakeup, readiness, allocation and selection.
    logic [RS_DEPTH-1:0]  src1_wake_s;
    logic [RS_DEPTH-1:0]  src2_wake_s;
    logic [RS_DEPTH-1:0]  ready_s;
    logic [DISP_W-1:0]    disp_w1_s;
    logic [DISP_W-1:0]    disp_w2_s;
    logic [RS_DEPTH-1:0]  alloc_oh_s   [DISP_W];
    logic [RS_DEPTH-1:0]  we_oh_s      [DISP_W];
    logic [RS_DEPTH-1:0]  younger_s    [DISP_W];
    logic [RS_DEPTH-1:0]  new_any_s;
    logic [RS_DEPTH-1:0]  issue_oh_s   [ISSUE_W];
    logic [RS_DEPTH-1:0]  issued_s;

    // True when any valid CDB lane broadcasts the given tag.
    function automatic logic cdb_hit(input logic [PR_W-1:0] tag,
                                     input logic [CDB_W-1:0] vld,
                                     input logic [CDB_W-1:0][PR_W-1:0] tags);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < CDB_W; c++) begin
            hit = hit | (vld[c] & (tags[c] == tag));
        end
        return hit;
    endfunction

    // Free-entry count and per-lane stall, from registered valid bits only.
    always_comb begin
        free_count = {CNT_W{1'b0}};
        for (int i = 0; i < RS_DEPTH; i++) begin
            free_count = free_count + CNT_W'(~valid_r[i]);
        end
        for (int k = 0; k < DISP_W; k++) begin
            disp_stall[k] = (int'(free_count) < (k + 1));
        end
    end

    // Lane k takes the (k+1)-th lowest-index free entry, regardless of which lanes are valid.
    always_comb begin
        int seen;
        seen = 0;
        for (int k = 0; k < DISP_W; k++) begin
            alloc_oh_s[k] = {RS_DEPTH{1'b0}};
        end
        for (int i = 0; i < RS_DEPTH; i++) begin
            for (int k = 0; k < DISP_W; k++) begin
                alloc_oh_s[k][i] = ~valid_r[i] & (seen == k);
            end
            seen = seen + (valid_r[i] ? 0 : 1);
        end
        for (int k = 0; k < DISP_W; k++) begin
            we_oh_s[k] = alloc_oh_s[k] &
                         {RS_DEPTH{disp_valid[k] & ~disp_stall[k] & ~squash}};
        end
    end

    // Wakeup of stored and dispatching sources, then per-entry readiness.
    always_comb begin
        logic fu_ok;
        logic sq_ok;
        for (int k = 0; k < DISP_W; k++) begin
            disp_w1_s[k] = disp_src1_rdy[k] | cdb_hit(disp_src1_pr[k], cdb_valid, cdb_tag);
            disp_w2_s[k] = disp_src2_rdy[k] | cdb_hit(disp_src2_pr[k], cdb_valid, cdb_tag);
        end
        for (int i = 0; i < RS_DEPTH; i++) begin
            src1_wake_s[i] = src1_rdy_r[i] | cdb_hit(src1_pr_r[i], cdb_valid, cdb_tag);
            src2_wake_s[i] = src2_rdy_r[i] | cdb_hit(src2_pr_r[i], cdb_valid, cdb_tag);
            if (int'(fu_sel_r[i]) < NUM_FU) begin
                fu_ok = ~fu_stall[fu_sel_r[i]];
            end else begin
                fu_ok = 1'b0;
            end
            if (int'(sq_idx_r[i]) < SQ_DEPTH) begin
                sq_ok = sq_ready[sq_idx_r[i]];
            end else begin
                sq_ok = 1'b0;
            end
            ready_s[i] = valid_r[i] & src1_wake_s[i] & src2_wake_s[i] & fu_ok & sq_ok;
        end
    end

    // Oldest-first select: a lane wins the candidate no other candidate is older than,
    // then the winner is removed before the next lane looks.
    always_comb begin
        logic [RS_DEPTH-1:0] cand;
        logic found;
        logic older;
        logic take;
        cand = ready_s;
        issued_s = {RS_DEPTH{1'b0}};
        for (int n = 0; n < ISSUE_W; n++) begin
            issue_oh_s[n] = {RS_DEPTH{1'b0}};
            found = 1'b0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                older = 1'b0;
                for (int j = 0; j < RS_DEPTH; j++) begin
                    older = older | (cand[j] & age_r[j][i] & (j != i));
                end
                // found keeps the lane one-hot even if the matrix were ever inconsistent
                take = cand[i] & ~older & ~found;
                issue_oh_s[n][i] = take;
                found = found | take;
            end
            cand = cand & ~issue_oh_s[n];
            issued_s = issued_s | issue_oh_s[n];
        end
    end

    // Issue lane fields, one-hot muxed from the winning entry; unused lanes drive zero.
    always_comb begin
        for (int n = 0; n < ISSUE_W; n++) begin
            issue_valid[n]   = |issue_oh_s[n];
            issue_src1_pr[n] = {PR_W{1'b0}};
            issue_src2_pr[n] = {PR_W{1'b0}};
            issue_fu_sel[n]  = {FU_W{1'b0}};
            issue_sq_idx[n]  = {SQ_W{1'b0}};
            issue_payload[n] = {PAYLOAD_W{1'b0}};
            for (int i = 0; i < RS_DEPTH; i++) begin
                issue_src1_pr[n] = issue_src1_pr[n] | (issue_oh_s[n][i] ? src1_pr_r[i] : {PR_W{1'b0}});
                issue_src2_pr[n] = issue_src2_pr[n] | (issue_oh_s[n][i] ? src2_pr_r[i] : {PR_W{1'b0}});
                issue_fu_sel[n]  = issue_fu_sel[n]  | (issue_oh_s[n][i] ? fu_sel_r[i]  : {FU_W{1'b0}});
                issue_sq_idx[n]  = issue_sq_idx[n]  | (issue_oh_s[n][i] ? sq_idx_r[i]  : {SQ_W{1'b0}});
                issue_payload[n] = issue_payload[n] | (issue_oh_s[n][i] ? payload_r[i] : {PAYLOAD_W{1'b0}});
            end
        end
    end

    // Age matrix update: new entries are younger than all valid entries and than
    // lower lanes; a new entry's row holds only its same-cycle younger lanes.
    // Rows of invalid entries may hold stale bits; selection never looks at them.
    always_comb begin
        new_any_s = {RS_DEPTH{1'b0}};
        for (int k = 0; k < DISP_W; k++) begin
            new_any_s = new_any_s | we_oh_s[k];
            younger_s[k] = {RS_DEPTH{1'b0}};
            for (int m = k + 1; m < DISP_W; m++) begin
                younger_s[k] = younger_s[k] | we_oh_s[m];
            end
        end
        for (int i = 0; i < RS_DEPTH; i++) begin
            age_nxt_s[i] = age_r[i] | (valid_r[i] ? new_any_s : {RS_DEPTH{1'b0}});
            for (int k = 0; k < DISP_W; k++) begin
                age_nxt_s[i] = we_oh_s[k][i] ? younger_s[k] : age_nxt_s[i];
            end
        end
    end

    // Entry next state: issued entries drop valid, written entries take lane data.
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            valid_nxt_s[i]    = valid_r[i] & ~issued_s[i];
            src1_rdy_nxt_s[i] = src1_wake_s[i];
            src2_rdy_nxt_s[i] = src2_wake_s[i];
            src1_pr_nxt_s[i]  = src1_pr_r[i];
            src2_pr_nxt_s[i]  = src2_pr_r[i];
            fu_sel_nxt_s[i]   = fu_sel_r[i];
            sq_idx_nxt_s[i]   = sq_idx_r[i];
            payload_nxt_s[i]  = payload_r[i];
            for (int k = 0; k < DISP_W; k++) begin
                valid_nxt_s[i]    = valid_nxt_s[i] | we_oh_s[k][i];
                src1_rdy_nxt_s[i] = we_oh_s[k][i] ? disp_w1_s[k]    : src1_rdy_nxt_s[i];
                src2_rdy_nxt_s[i] = we_oh_s[k][i] ? disp_w2_s[k]    : src2_rdy_nxt_s[i];
                src1_pr_nxt_s[i]  = we_oh_s[k][i] ? disp_src1_pr[k] : src1_pr_nxt_s[i];
                src2_pr_nxt_s[i]  = we_oh_s[k][i] ? disp_src2_pr[k] : src2_pr_nxt_s[i];
                fu_sel_nxt_s[i]   = we_oh_s[k][i] ? disp_fu_sel[k]  : fu_sel_nxt_s[i];
                sq_idx_nxt_s[i]   = we_oh_s[k][i] ? disp_sq_idx[k]  : sq_idx_nxt_s[i];
                payload_nxt_s[i]  = we_oh_s[k][i] ? disp_payload[k] : payload_nxt_s[i];
            end
        end
    end

    // State register: reset clears everything, squash clears valid and age only.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r    <= {RS_DEPTH{1'b0}};
            src1_rdy_r <= {RS_DEPTH{1'b0}};
            src2_rdy_r <= {RS_DEPTH{1'b0}};
            for (int i = 0; i < RS_DEPTH; i++) begin
                src1_pr_r[i] <= {PR_W{1'b0}};
                src2_pr_r[i] <= {PR_W{1'b0}};
                fu_sel_r[i]  <= {FU_W{1'b0}};
                sq_idx_r[i]  <= {SQ_W{1'b0}};
                payload_r[i] <= {PAYLOAD_W{1'b0}};
                age_r[i]     <= {RS_DEPTH{1'b0}};
            end
        end else if (squash) begin
            valid_r <= {RS_DEPTH{1'b0}};
            for (int i = 0; i < RS_DEPTH; i++) begin
                age_r[i] <= {RS_DEPTH{1'b0}};
            end
        end else begin
            valid_r    <= valid_nxt_s;
            src1_rdy_r <= src1_rdy_nxt_s;
            src2_rdy_r <= src2_rdy_nxt_s;
            src1_pr_r  <= src1_pr_nxt_s;
            src2_pr_r  <= src2_pr_nxt_s;
            fu_sel_r   <= fu_sel_nxt_s;
            sq_idx_r   <= sq_idx_nxt_s;
            payload_r  <= payload_nxt_s;
            age_r      <= age_nxt_s;
        end
    end

endmodule

// File: tb/tb_rs_age_param.sv
// Directed bench for rs_age_param. Stimulus pushes the expected issue events
// (id, lane, cycle, FU class) into a queue; a monitor on the falling edge pops
// and compares whenever an issue lane is valid. Registered status outputs are
// compared directly against hand-computed constants.
module tb_rs_age_param;

    logic clk = 1'b0;
    logic rst;
    logic [2:0]          disp_valid;
    logic [2:0][5:0]     disp_src1_pr, disp_src2_pr;
    logic [2:0]          disp_src1_rdy, disp_src2_rdy;
    logic [2:0][1:0]     disp_fu_sel;
    logic [2:0][2:0]     disp_sq_idx;
    logic [2:0][127:0]   disp_payload;
    logic [2:0]          disp_stall;
    logic [4:0]          free_count;
    logic [2:0]          cdb_valid;
    logic [2:0][5:0]     cdb_tag;
    logic [7:0]          sq_ready;
    logic [3:0]          fu_stall;
    logic                squash;
    logic [2:0]          issue_valid;
    logic [2:0][5:0]     issue_src1_pr, issue_src2_pr;
    logic [2:0][1:0]     issue_fu_sel;
    logic [2:0][2:0]     issue_sq_idx;
    logic [2:0][127:0]   issue_payload;

    typedef struct {
        logic [15:0] id;
        int          lane;
        int          cyc;
        logic [1:0]  fu;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    rs_age_param dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid),
        .disp_src1_pr(disp_src1_pr), .disp_src2_pr(disp_src2_pr),
        .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
        .disp_fu_sel(disp_fu_sel), .disp_sq_idx(disp_sq_idx),
        .disp_payload(disp_payload),
        .disp_stall(disp_stall), .free_count(free_count),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .sq_ready(sq_ready), .fu_stall(fu_stall), .squash(squash),
        .issue_valid(issue_valid),
        .issue_src1_pr(issue_src1_pr), .issue_src2_pr(issue_src2_pr),
        .issue_fu_sel(issue_fu_sel), .issue_sq_idx(issue_sq_idx),
        .issue_payload(issue_payload)
    );

    always #5 clk = ~clk;

    // Cycle counter used to stamp expected issue cycles.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop and compare on every valid issue lane; idle lanes must be all zero.
    always @(negedge clk) begin
        if (!rst) begin
            for (int n = 0; n < 3; n++) begin
                if (issue_valid[n]) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_issue: lane %0d cycle %0d payload id %0d, required no issue",
                                 n, cyc, issue_payload[n][15:0]);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        if (issue_payload[n] !== {8{e.id}} || n != e.lane || cyc != e.cyc ||
                            issue_fu_sel[n] !== e.fu) begin
                            errors++;
                            $display("FAIL issue_event: actual id %0d lane %0d cycle %0d fu %0d, required id %0d lane %0d cycle %0d fu %0d",
                                     issue_payload[n][15:0], n, cyc, issue_fu_sel[n],
                                     e.id, e.lane, e.cyc, e.fu);
                        end
                    end
                end else begin
                    checks++;
                    if (issue_payload[n] !== 128'd0 || issue_src1_pr[n] !== 6'd0 ||
                        issue_src2_pr[n] !== 6'd0 || issue_fu_sel[n] !== 2'd0 ||
                        issue_sq_idx[n] !== 3'd0) begin
                        errors++;
                        $display("FAIL idle_lane_zero: lane %0d cycle %0d has nonzero fields, required all zero", n, cyc);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        disp_valid    = 3'd0;
        disp_src1_pr  = '0;
        disp_src2_pr  = '0;
        disp_src1_rdy = 3'd0;
        disp_src2_rdy = 3'd0;
        disp_fu_sel   = '0;
        disp_sq_idx   = '0;
        disp_payload  = '0;
        cdb_valid     = 3'd0;
        cdb_tag       = '0;
        squash        = 1'b0;
    endtask

    // End the current cycle: wait for the edge, then drop one-cycle inputs.
    task automatic tick();
        @(posedge clk);
        #1;
        clear_inputs();
        #1;
    endtask

    task automatic set_lane(input int k, input logic [15:0] id,
                            input logic [5:0] p1, input logic r1,
                            input logic [5:0] p2, input logic r2,
                            input logic [1:0] fu, input logic [2:0] sq);
        disp_valid[k]    = 1'b1;
        disp_src1_pr[k]  = p1;
        disp_src1_rdy[k] = r1;
        disp_src2_pr[k]  = p2;
        disp_src2_rdy[k] = r2;
        disp_fu_sel[k]   = fu;
        disp_sq_idx[k]   = sq;
        disp_payload[k]  = {8{id}};
    endtask

    task automatic expect_issue(input logic [15:0] id, input int lane,
                                input int at, input logic [1:0] fu);
        exp_t e;
        e.id = id; e.lane = lane; e.cyc = at; e.fu = fu;
        sb.push_back(e);
    endtask

    task automatic set_cdb(input int c, input logic [5:0] tag);
        cdb_valid[c] = 1'b1;
        cdb_tag[c]   = tag;
    endtask

    initial begin
        rst      = 1'b1;
        sq_ready = 8'hFF;
        fu_stall = 4'd0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        // Reset state.
        chk("reset_free_count", free_count, 16);
        chk("reset_disp_stall", disp_stall, 0);
        chk("reset_issue_valid", issue_valid, 0);

        // Oldest-first: X0/X1 occupy and vacate slots 0-1 so A-C sit above D-E by index.
        set_lane(0, 16'd10, 6'd1, 1'b1, 6'd2, 1'b1, 2'd0, 3'd0);
        set_lane(1, 16'd11, 6'd1, 1'b1, 6'd2, 1'b1, 2'd0, 3'd0);
        expect_issue(16'd10, 0, cyc + 1, 2'd0);
        expect_issue(16'd11, 1, cyc + 1, 2'd0);
        tick();
        chk("free_after_x", free_count, 14);
        set_lane(0, 16'd1, 6'd1, 1'b1, 6'd5, 1'b0, 2'd0, 3'd0);
        set_lane(1, 16'd2, 6'd1, 1'b1, 6'd5, 1'b0, 2'd0, 3'd0);
        set_lane(2, 16'd3, 6'd1, 1'b1, 6'd5, 1'b0, 2'd0, 3'd0);
        tick();
        chk("free_after_abc", free_count, 13);
        set_lane(0, 16'd4, 6'd1, 1'b1, 6'd2, 1'b1, 2'd2, 3'd0);
        set_lane(1, 16'd5, 6'd1, 1'b1, 6'd2, 1'b1, 2'd2, 3'd0);
        tick();
        // D and E are ready and in lower slots, but A-C are older.
        set_cdb(1, 6'd5);
        expect_issue(16'd1, 0, cyc, 2'd0);
        expect_issue(16'd2, 1, cyc, 2'd0);
        expect_issue(16'd3, 2, cyc, 2'd0);
        expect_issue(16'd4, 0, cyc + 1, 2'd2);
        expect_issue(16'd5, 1, cyc + 1, 2'd2);
        tick();
        tick();
        chk("free_after_oldest", free_count, 16);

        // Same-cycle wakeup on a dispatching lane.
        set_lane(0, 16'd20, 6'd9, 1'b0, 6'd2, 1'b1, 2'd1, 3'd0);
        set_cdb(2, 6'd9);
        expect_issue(16'd20, 0, cyc + 1, 2'd1);
        tick();
        // Same tag on lanes with cdb_valid low must be ignored.
        set_lane(0, 16'd21, 6'd9, 1'b0, 6'd2, 1'b1, 2'd1, 3'd0);
        cdb_tag[2] = 6'd9;
        cdb_tag[0] = 6'd9;
        tick();
        repeat (3) tick();
        chk("free_waiting_g", free_count, 15);
        squash = 1'b1;
        tick();
        chk("free_after_squash_g", free_count, 16);

        // Fill all 16 entries, none ready (src1 tag 30+i).
        for (int b = 0; b < 6; b++) begin
            for (int k = 0; k < 3; k++) begin
                if (b * 3 + k < 16) begin
                    set_lane(k, 16'(40 + b * 3 + k), 6'(30 + b * 3 + k), 1'b0,
                             6'd2, 1'b1, 2'd0, 3'd0);
                end
            end
            tick();
        end
        chk("full_free_count", free_count, 0);
        chk("full_disp_stall", disp_stall, 7);
        // Dispatch while full is dropped; wake the two oldest entries.
        set_lane(0, 16'd97, 6'd1, 1'b1, 6'd2, 1'b1, 2'd0, 3'd0);
        set_lane(1, 16'd98, 6'd1, 1'b1, 6'd2, 1'b1, 2'd0, 3'd0);
        set_lane(2, 16'd99, 6'd1, 1'b1, 6'd2, 1'b1, 2'd0, 3'd0);
        set_cdb(0, 6'd30);
        set_cdb(1, 6'd31);
        expect_issue(16'd40, 0, cyc, 2'd0);
        expect_issue(16'd41, 1, cyc, 2'd0);
        #1;
        chk("full_free_during_issue", free_count, 0);
        tick();
        chk("free_after_two", free_count, 2);
        chk("stall_after_two", disp_stall, 4);
        set_cdb(0, 6'd32);
        set_cdb(1, 6'd33);
        set_cdb(2, 6'd34);
        expect_issue(16'd42, 0, cyc, 2'd0);
        expect_issue(16'd43, 1, cyc, 2'd0);
        expect_issue(16'd44, 2, cyc, 2'd0);
        tick();
        chk("free_after_five", free_count, 5);
        chk("stall_after_five", disp_stall, 0);
        set_cdb(0, 6'd35);
        expect_issue(16'd45, 0, cyc, 2'd0);
        tick();
        chk("free_ten_valid", free_count, 6);

        // Squash with 10 valid entries and a 3-wide ready dispatch.
        squash = 1'b1;
        set_lane(0, 16'd90, 6'd1, 1'b1, 6'd2, 1'b1, 2'd0, 3'd0);
        set_lane(1, 16'd91, 6'd1, 1'b1, 6'd2, 1'b1, 2'd0, 3'd0);
        set_lane(2, 16'd92, 6'd1, 1'b1, 6'd2, 1'b1, 2'd0, 3'd0);
        tick();
        chk("squash_free_count", free_count, 16);
        chk("squash_issue_valid", issue_valid, 0);
        // Tags of flushed entries must not revive anything.
        for (int t = 36; t < 46; t += 3) begin
            for (int c = 0; c < 3; c++) begin
                if (t + c < 46) set_cdb(c, 6'(t + c));
            end
            tick();
        end

        // FU and SQ gating: P class 1 stalled, R waits on sq_ready[3], Q goes first.
        fu_stall = 4'b0010;
        sq_ready = 8'hF7;
        set_lane(0, 16'd50, 6'd1, 1'b1, 6'd2, 1'b1, 2'd1, 3'd0);
        set_lane(1, 16'd51, 6'd1, 1'b1, 6'd2, 1'b1, 2'd0, 3'd0);
        set_lane(2, 16'd52, 6'd1, 1'b1, 6'd2, 1'b1, 2'd0, 3'd3);
        expect_issue(16'd51, 0, cyc + 1, 2'd0);
        tick();
        tick();
        tick();
        fu_stall = 4'd0;
        expect_issue(16'd50, 0, cyc, 2'd1);
        tick();
        tick();
        sq_ready = 8'hFF;
        expect_issue(16'd52, 0, cyc, 2'd0);
        tick();
        repeat (3) tick();
        chk("final_free_count", free_count, 16);
        chk("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
